rob_param: RTL and testbench
============================

Name: rob_param

Overview:
Parametrised in-order reorder buffer for the out-of-order core. It allocates entries at issue and accepts results from N writeback channels. It serves operand lookups to issue/RS and retires one entry per cycle in program order. Over the previous ROB it adds:
- count-based full/empty with no wasted slot;
- configurable depth and writeback channel count;
- operand query ports with same-cycle bypass;
- a store-commit handshake with the LSB;
- a registered flush on mispredict.

Parameters:
ROB_LOG, 4, log2 of entry count; DEPTH = 2**ROB_LOG.
WB_N, 2, number of writeback channels (channel 0 = ALU/branch, 1 = LSB load).
OP_W, 6, width of the opcode class field (from the shared package).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global ready; 0 freezes all state
issue_valid  in  1  allocate an entry this cycle
issue_op  in  OP_W  op class (branch / store / jump / other)
issue_dest  in  5  destination register (0 = none)
issue_id  out  ROB_LOG  id the next issued entry receives (= tail, combinational)
alloc_ready  out  1  issue may be asserted next cycle (count <= DEPTH-2, or count == DEPTH-1 with no issue this cycle)
wb_valid  in  WB_N  per-channel result valid
wb_id  in  WB_N*ROB_LOG  per-channel entry id
wb_value  in  WB_N*32  per-channel result
wb_redirect  in  WB_N  per-channel mispredict flag
wb_target  in  WB_N*32  per-channel corrected PC
q_id  in  2*ROB_LOG  two operand query ids
q_ready  out  2  entry result available (combinational)
q_value  out  2*32  entry result (combinational)
commit_valid  out  1  register-write pulse
commit_dest  out  5  register index
commit_id  out  ROB_LOG  id of the committed entry
commit_value  out  32  committed value
store_go  out  1  one-cycle pulse: LSB may perform the head store
store_done  in  1  LSB finished the store
flush  out  1  one-cycle pulse: squash all in-flight state
flush_pc  out  32  fetch restart PC
empty  out  1  count == 0

Behaviour:
- Reset (async): head=tail=0, count=0, all busy/ready bits 0, state IDLE. commit_valid, store_go and flush are 0; commit_*, flush_pc are 0.
- rdy=0: all registers hold, except pulse outputs, which are driven 0 at the next edge.
- Allocation: if issue_valid && count<DEPTH, entry[tail] gets busy=1, ready=0, op, dest, redirect=0; tail wraps modulo DEPTH. issue_valid while full is ignored, but flagged by the assertion.
- Writeback: for each channel with wb_valid and entry[wb_id] busy, set ready=1 and latch value, redirect and target. Writeback to a non-busy id is ignored. Two channels hitting the same id in one cycle: the lowest channel wins.
- Query: q_ready = busy && (ready || a same-cycle wb match). q_value takes the bypassed value first, lowest channel first.
- Commit FSM, states IDLE and WAIT_ST:
  - IDLE, head busy and ready:
    - store: pulse store_go and enter WAIT_ST. The head is not retired yet.
    - redirect=1: retire the head. Pulse commit_valid if dest!=0 and op is not a branch. Pulse flush with flush_pc=target. Clear all entries, head, tail, count and state on the same edge.
    - otherwise: retire the head and pulse commit_valid if dest!=0 and op is not a branch.
  - WAIT_ST: on store_done, retire the head and return to IDLE. No other commit happens meanwhile.
- Count: count' = count + issue_accepted - retired. Simultaneous issue and retire keep count unchanged, including at DEPTH and at 0.
- Flush edge: an issue in the same cycle is discarded, and writebacks in that cycle are dropped.
- One retire per cycle at most; commit latency from ready to pulse is 1 cycle.

Decomposition:
- Shared package (config include): OP_W, op-class constants, and an is_branch/is_store decode.
- Natural sub-module rob_wb_merge: per-channel priority match and bypass mux, instantiated for the entry update and for each query port.

Test Plan:
- Reset mid-stream with count=5: assert rst asynchronously -> empty=1, issue_id=0 and no pulses, without waiting for a clock edge.
- Fill all 16 entries, writeback in reverse order -> commits appear in issue order 0..15, one per cycle; alloc_ready=0 at count 15 with issue asserted.
- Full ROB plus issue and a retiring head in the same cycle -> the new entry takes the freed slot via wrap, and count stays at 16.
- Store at head ready -> store_go pulse, 3-cycle hold with no commits, then store_done -> next entry commits the following cycle.
- Branch id 2 writes back with redirect=1, target=0x1000, while ids 3..6 are ready -> flush=1 with flush_pc=0x1000 after id 2 retires, empty=1 next cycle, and ids 3..6 never commit.
- Both wb channels write id 4 with values 7 and 9, plus a same-cycle query on 4 -> q_value=7 and committed value 7.

Source files
------------

// File: rtl/rob_param_pkg.sv
// rob_param_pkg: op classes, commit FSM states and op-class decode
// shared by the reorder buffer and its bench.
package rob_param_pkg;
    localparam int OP_W = 6;
    localparam logic [OP_W-1:0] OP_OTHER  = 6'd0;
    localparam logic [OP_W-1:0] OP_BRANCH = 6'd1;
    localparam logic [OP_W-1:0] OP_STORE  = 6'd2;
    localparam logic [OP_W-1:0] OP_JUMP   = 6'd3;

    typedef enum logic {IDLE, WAIT_ST} commit_state_t;

    function automatic logic is_branch(input logic [OP_W-1:0] op);
        return op == OP_BRANCH;
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return op == OP_STORE;
    endfunction
endpackage

// File: rtl/rob_wb_merge.sv
// rob_wb_merge: matches all writeback channels against one entry id;
// the lowest-numbered matching channel supplies the result.
module rob_wb_merge #(
    parameter int ROB_LOG = 4,
    parameter int WB_N    = 2
) (
    input  logic [ROB_LOG-1:0]      id,
    input  logic [WB_N-1:0]         wb_valid,
    input  logic [WB_N*ROB_LOG-1:0] wb_id,
    input  logic [WB_N*32-1:0]      wb_value,
    input  logic [WB_N-1:0]         wb_redirect,
    input  logic [WB_N*32-1:0]      wb_target,
    output logic                    hit,
    output logic [31:0]             value,
    output logic                    redirect,
    output logic [31:0]             target
);
    // scan high to low so the lowest matching channel is written last
    always_comb begin
        hit = 1'b0;
        value = '0;
        redirect = 1'b0;
        target = '0;
        for (int c = WB_N - 1; c >= 0; c--)
            if (wb_valid[c] && wb_id[c*ROB_LOG +: ROB_LOG] == id) begin
                hit = 1'b1;
                value = wb_value[c*32 +: 32];
                redirect = wb_redirect[c];
                target = wb_target[c*32 +: 32];
            end
    end
endmodule

// File: rtl/rob_param.sv
// rob_param: in-order reorder buffer with N writeback channels, bypassed
// operand queries, store-commit handshake and registered mispredict flush.
module rob_param #(
    parameter int ROB_LOG = 4,
    parameter int WB_N    = 2,
    parameter int OP_W    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    issue_valid,
    input  logic [OP_W-1:0]         issue_op,
    input  logic [4:0]              issue_dest,
    output logic [ROB_LOG-1:0]      issue_id,
    output logic                    alloc_ready,
    input  logic [WB_N-1:0]         wb_valid,
    input  logic [WB_N*ROB_LOG-1:0] wb_id,
    input  logic [WB_N*32-1:0]      wb_value,
    input  logic [WB_N-1:0]         wb_redirect,
    input  logic [WB_N*32-1:0]      wb_target,
    input  logic [2*ROB_LOG-1:0]    q_id,
    output logic [1:0]              q_ready,
    output logic [2*32-1:0]         q_value,
    output logic                    commit_valid,
    output logic [4:0]              commit_dest,
    output logic [ROB_LOG-1:0]      commit_id,
    output logic [31:0]             commit_value,
    output logic                    store_go,
    input  logic                    store_done,
    output logic                    flush,
    output logic [31:0]             flush_pc,
    output logic                    empty
);
    import rob_param_pkg::*;

    localparam int DEPTH = 2 ** ROB_LOG;
    localparam logic [ROB_LOG:0] FULL = (ROB_LOG + 1)'(DEPTH);
    localparam logic [ROB_LOG:0] LAST = (ROB_LOG + 1)'(DEPTH - 1);

    logic [DEPTH-1:0] busy, ready, redir;
    logic [OP_W-1:0] op [DEPTH];
    logic [4:0] dest [DEPTH];
    logic [31:0] value [DEPTH];
    logic [31:0] target [DEPTH];
    logic [ROB_LOG-1:0] head, tail;
    logic [ROB_LOG:0] count;
    commit_state_t state;

    logic [DEPTH-1:0] e_hit, e_redir;
    logic [31:0] e_value [DEPTH];
    logic [31:0] e_target [DEPTH];
    logic [1:0] unused_redir;
    logic [31:0] unused_target [2];

    logic head_done, start_store, retire, do_flush, accept, commit_now;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        rob_wb_merge #(.ROB_LOG(ROB_LOG), .WB_N(WB_N)) u_merge (
            .id(ROB_LOG'(i)), .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
            .wb_redirect(wb_redirect), .wb_target(wb_target),
            .hit(e_hit[i]), .value(e_value[i]), .redirect(e_redir[i]), .target(e_target[i])
        );
    end

    for (genvar j = 0; j < 2; j++) begin : g_q
        logic [ROB_LOG-1:0] qi;
        logic hit;
        logic [31:0] bv;
        assign qi = q_id[j*ROB_LOG +: ROB_LOG];
        rob_wb_merge #(.ROB_LOG(ROB_LOG), .WB_N(WB_N)) u_merge (
            .id(qi), .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
            .wb_redirect(wb_redirect), .wb_target(wb_target),
            .hit(hit), .value(bv), .redirect(unused_redir[j]), .target(unused_target[j])
        );
        assign q_ready[j] = busy[qi] && (ready[qi] || hit);
        assign q_value[j*32 +: 32] = hit ? bv : value[qi];
    end

    assign issue_id = tail;
    assign empty = count == '0;
    assign alloc_ready = count < LAST || (count == LAST && !issue_valid);

    always_comb begin
        head_done = busy[head] && ready[head];
        start_store = rdy && state == IDLE && head_done && is_store(op[head]);
        retire = rdy && (state == IDLE ? head_done && !is_store(op[head]) : store_done);
        do_flush = retire && state == IDLE && redir[head];
        accept = rdy && issue_valid && (count < FULL || retire);
        commit_now = retire && state == IDLE && dest[head] != 5'd0 && !is_branch(op[head]);
    end

    // a retiring head frees its slot in time for an issue on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            ready <= '0;
            redir <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
            state <= IDLE;
            commit_valid <= 1'b0;
            commit_dest <= '0;
            commit_id <= '0;
            commit_value <= '0;
            store_go <= 1'b0;
            flush <= 1'b0;
            flush_pc <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op[i] <= '0;
                dest[i] <= '0;
                value[i] <= '0;
                target[i] <= '0;
            end
        end else begin
            commit_valid <= commit_now;
            store_go <= start_store;
            flush <= do_flush;
            if (commit_now) begin
                commit_dest <= dest[head];
                commit_id <= head;
                commit_value <= value[head];
            end
            if (do_flush) begin
                flush_pc <= target[head];
                busy <= '0;
                ready <= '0;
                redir <= '0;
                head <= '0;
                tail <= '0;
                count <= '0;
                state <= IDLE;
            end else if (rdy) begin
                for (int i = 0; i < DEPTH; i++)
                    if (e_hit[i] && busy[i]) begin
                        ready[i] <= 1'b1;
                        value[i] <= e_value[i];
                        redir[i] <= e_redir[i];
                        target[i] <= e_target[i];
                    end
                if (retire) begin
                    busy[head] <= 1'b0;
                    ready[head] <= 1'b0;
                    head <= head + 1'b1;
                end
                if (accept) begin
                    busy[tail] <= 1'b1;
                    ready[tail] <= 1'b0;
                    redir[tail] <= 1'b0;
                    op[tail] <= issue_op;
                    dest[tail] <= issue_dest;
                    tail <= tail + 1'b1;
                end
                count <= count + (ROB_LOG + 1)'(accept) - (ROB_LOG + 1)'(retire);
                state <= start_store ? WAIT_ST : (state == WAIT_ST && store_done) ? IDLE : state;
            end
        end
    end

    always_ff @(posedge clk)
        if (!rst && rdy) assert (!(issue_valid && count == FULL && !retire));
endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: directed scenarios plus random traffic, checked against a
// queue-based model of the in-flight instruction window.
module tb_rob_param;
    import rob_param_pkg::*;

    localparam int RL = 4;
    localparam int D = 16;
    localparam int WN = 2;

    logic clk = 1'b0, rst = 1'b1, rdy = 1'b0;
    logic issue_valid = 1'b0;
    logic [OP_W-1:0] issue_op = '0;
    logic [4:0] issue_dest = '0;
    logic [RL-1:0] issue_id;
    logic alloc_ready;
    logic [WN-1:0] wb_valid = '0, wb_redirect = '0;
    logic [WN*RL-1:0] wb_id = '0;
    logic [WN*32-1:0] wb_value = '0, wb_target = '0;
    logic [2*RL-1:0] q_id = '0;
    logic [1:0] q_ready;
    logic [63:0] q_value;
    logic commit_valid;
    logic [4:0] commit_dest;
    logic [RL-1:0] commit_id;
    logic [31:0] commit_value;
    logic store_go, store_done = 1'b0, flush;
    logic [31:0] flush_pc;
    logic empty;

    rob_param #(.ROB_LOG(RL), .WB_N(WN), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_dest(issue_dest),
        .issue_id(issue_id), .alloc_ready(alloc_ready),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
        .wb_redirect(wb_redirect), .wb_target(wb_target),
        .q_id(q_id), .q_ready(q_ready), .q_value(q_value),
        .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_id(commit_id),
        .commit_value(commit_value), .store_go(store_go), .store_done(store_done),
        .flush(flush), .flush_pc(flush_pc), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        logic [OP_W-1:0] op;
        logic [4:0] dest;
        bit rd;
        logic [31:0] val;
        bit redir;
        logic [31:0] tgt;
    } ent_t;

    ent_t rob[$];
    int nid = 0;
    bit waiting = 0;
    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find(input int id);
        foreach (rob[i]) if (rob[i].id == id) return i;
        return -1;
    endfunction

    function automatic int pick();
        if (rob.size() > 0 && $urandom_range(0, 4) != 0) return rob[$urandom_range(0, rob.size() - 1)].id;
        return int'($urandom_range(0, D - 1));
    endfunction

    task automatic idle();
        rdy = 1'b1;
        issue_valid = 1'b0;
        wb_valid = '0;
        wb_redirect = '0;
        store_done = 1'b0;
        q_id = '0;
    endtask

    task automatic set_iss(input logic [OP_W-1:0] o, input logic [4:0] d);
        issue_valid = 1'b1;
        issue_op = o;
        issue_dest = d;
    endtask

    task automatic set_wb(input int c, input int id, input logic [31:0] v, input bit r, input logic [31:0] t);
        wb_valid[c] = 1'b1;
        wb_id[c*RL +: RL] = RL'(id);
        wb_value[c*32 +: 32] = v;
        wb_redirect[c] = r;
        wb_target[c*32 +: 32] = t;
    endtask

    // checks combinational outputs, advances the model one clock, checks pulses
    task automatic cycle();
        int sz, i, qid;
        bit hit, retire, e_cv, e_sg, e_fl;
        logic [31:0] v, e_val, e_pc;
        logic [4:0] e_dest;
        int e_id;
        ent_t n;
        #1;
        sz = rob.size();
        check("issue_id", 64'(issue_id), 64'(nid));
        check("empty", 64'(empty), 64'(sz == 0));
        check("alloc_ready", 64'(alloc_ready), 64'((sz <= D - 2) || (sz == D - 1 && !issue_valid)));
        for (int k = 0; k < 2; k++) begin
            qid = int'(q_id[k*RL +: RL]);
            i = find(qid);
            if (i >= 0) begin
                hit = 0;
                v = rob[i].val;
                for (int c = WN - 1; c >= 0; c--)
                    if (wb_valid[c] && int'(wb_id[c*RL +: RL]) == qid) begin
                        hit = 1;
                        v = wb_value[c*32 +: 32];
                    end
                check("q_ready", 64'(q_ready[k]), 64'(rob[i].rd || hit));
                if (rob[i].rd || hit) check("q_value", 64'(q_value[k*32 +: 32]), 64'(v));
            end else check("q_ready_idle", 64'(q_ready[k]), 64'd0);
        end
        retire = 0; e_cv = 0; e_sg = 0; e_fl = 0;
        e_val = '0; e_pc = '0; e_dest = '0; e_id = 0;
        if (rdy) begin
            if (waiting) begin
                if (store_done) begin
                    retire = 1;
                    waiting = 0;
                end
            end else if (sz > 0 && rob[0].rd) begin
                if (rob[0].op == OP_STORE) begin
                    e_sg = 1;
                    waiting = 1;
                end else begin
                    retire = 1;
                    e_cv = rob[0].dest != 0 && rob[0].op != OP_BRANCH;
                    e_dest = rob[0].dest;
                    e_id = rob[0].id;
                    e_val = rob[0].val;
                    e_fl = rob[0].redir;
                    e_pc = rob[0].tgt;
                end
            end
            if (e_fl) begin
                rob.delete();
                nid = 0;
            end else begin
                for (int c = WN - 1; c >= 0; c--)
                    if (wb_valid[c]) begin
                        i = find(int'(wb_id[c*RL +: RL]));
                        if (i >= 0) begin
                            rob[i].rd = 1;
                            rob[i].val = wb_value[c*32 +: 32];
                            rob[i].redir = wb_redirect[c];
                            rob[i].tgt = wb_target[c*32 +: 32];
                        end
                    end
                if (retire) void'(rob.pop_front());
                if (issue_valid && (sz < D || retire)) begin
                    n.id = nid; n.op = issue_op; n.dest = issue_dest;
                    n.rd = 0; n.val = '0; n.redir = 0; n.tgt = '0;
                    rob.push_back(n);
                    nid = (nid + 1) % D;
                end
            end
        end
        @(posedge clk);
        #1;
        check("commit_valid", 64'(commit_valid), 64'(e_cv));
        if (e_cv) begin
            check("commit_dest", 64'(commit_dest), 64'(e_dest));
            check("commit_id", 64'(commit_id), 64'(e_id));
            check("commit_value", 64'(commit_value), 64'(e_val));
        end
        check("store_go", 64'(store_go), 64'(e_sg));
        check("flush", 64'(flush), 64'(e_fl));
        if (e_fl) check("flush_pc", 64'(flush_pc), 64'(e_pc));
    endtask

    // asserts reset mid-cycle and checks outputs before any clock edge
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_issue_id", 64'(issue_id), 64'd0);
        check("rst_commit_valid", 64'(commit_valid), 64'd0);
        check("rst_store_go", 64'(store_go), 64'd0);
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_flush_pc", 64'(flush_pc), 64'd0);
        check("rst_commit_value", 64'(commit_value), 64'd0);
        rob.delete();
        nid = 0;
        waiting = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
    endtask

    task automatic rand_inputs();
        int sz;
        sz = rob.size();
        idle();
        rdy = $urandom_range(0, 9) != 0;
        if (sz < D && $urandom_range(0, 2) != 0)
            set_iss(OP_W'($urandom_range(0, 3)), $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 31)));
        for (int c = 0; c < WN; c++)
            if ($urandom_range(0, 1) == 1) set_wb(c, pick(), $urandom(), $urandom_range(0, 24) == 0, $urandom());
        store_done = $urandom_range(0, 2) == 0;
        q_id = {RL'(pick()), RL'(pick())};
    endtask

    initial begin
        idle();
        do_reset();

        // reset mid-stream: count 5 with a commit pulse in flight
        for (int i = 0; i < 6; i++) begin
            idle();
            set_iss(OP_OTHER, 5'(i + 1));
            if (i == 4) set_wb(0, 0, 32'h55, 0, 0);
            cycle();
        end
        do_reset();

        // fill, reverse-order writeback, full issue onto a retiring head
        for (int i = 0; i < D; i++) begin
            idle();
            set_iss(OP_OTHER, 5'(i + 1));
            if (i == D - 1) begin
                #1;
                check("alloc_ready_15", 64'(alloc_ready), 64'd0);
            end
            cycle();
        end
        for (int i = D - 1; i >= 0; i--) begin
            idle();
            set_wb(0, i, 32'(100 + i), 0, 0);
            cycle();
        end
        idle();
        set_iss(OP_OTHER, 5'd20);
        cycle();
        idle();
        #1;
        check("wrap_issue_id", 64'(issue_id), 64'd1);
        check("wrap_still_full", 64'(alloc_ready), 64'd0);
        check("wrap_not_empty", 64'(empty), 64'd0);
        for (int i = 0; i < D; i++) begin
            idle();
            cycle();
        end
        idle();
        set_wb(1, 0, 32'h77, 0, 0);
        cycle();
        for (int i = 0; i < 2; i++) begin
            idle();
            cycle();
        end

        // store handshake with a three-cycle hold
        do_reset();
        set_iss(OP_STORE, 5'd0);
        cycle();
        idle();
        set_iss(OP_OTHER, 5'd7);
        set_wb(0, 0, 32'h11, 0, 0);
        cycle();
        idle();
        set_wb(0, 1, 32'h22, 0, 0);
        cycle();
        check("store_go_pulse", 64'(store_go), 64'd1);
        for (int i = 0; i < 3; i++) begin
            idle();
            cycle();
        end
        idle();
        store_done = 1'b1;
        cycle();
        idle();
        cycle();
        check("store_next_commit", 64'({commit_valid, commit_id}), 64'({1'b1, 4'd1}));

        // mispredicted branch at id 2 squashes ready ids 3..6
        do_reset();
        for (int i = 0; i < 7; i++) begin
            idle();
            set_iss(i == 2 ? OP_BRANCH : OP_OTHER, i == 2 ? 5'd0 : 5'(i + 1));
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            set_wb(0, i == 0 ? 0 : 2 * i + 1, 32'(200 + i), 0, 0);
            set_wb(1, i == 0 ? 1 : 2 * i + 2, 32'(300 + i), 0, 0);
            cycle();
        end
        idle();
        set_wb(0, 2, 32'h0, 1, 32'h1000);
        cycle();
        idle();
        cycle();
        check("br_flush", 64'(flush), 64'd1);
        check("br_flush_pc", 64'(flush_pc), 64'h1000);
        idle();
        #1;
        check("br_empty", 64'(empty), 64'd1);
        for (int i = 0; i < 4; i++) begin
            idle();
            cycle();
        end

        // both channels write id 4; channel 0 wins for bypass and commit
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            set_iss(OP_OTHER, 5'(i + 1));
            cycle();
        end
        idle();
        set_wb(0, 0, 32'd1, 0, 0);
        set_wb(1, 1, 32'd2, 0, 0);
        cycle();
        idle();
        set_wb(0, 2, 32'd3, 0, 0);
        set_wb(1, 3, 32'd4, 0, 0);
        cycle();
        idle();
        set_wb(0, 4, 32'd7, 0, 0);
        set_wb(1, 4, 32'd9, 0, 0);
        q_id = {RL'(0), RL'(4)};
        #1;
        check("dual_q_ready", 64'(q_ready[0]), 64'd1);
        check("dual_q_value", 64'(q_value[31:0]), 64'd7);
        cycle();
        for (int i = 0; i < 6; i++) begin
            idle();
            cycle();
            if (commit_valid && commit_id == 4'd4) check("dual_commit_value", 64'(commit_value), 64'd7);
        end

        // random traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
